// File: rtl/div_clk_checker.sv
// rtl/div_clk_checker.sv - divided-clock phase checker: edge pulses, phase lengths, lock and error.
// Optional saturating err_cnt output enabled by defining DIV_CHK_ERR_CNT_EN.
module div_clk_checker #(
    parameter int CNT_W     = 8,
    parameter int LOCK_CNT  = 4,
    parameter int ERR_CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_d,
    input  logic [CNT_W-1:0] exp_half,
    output logic             rise_pls,
    output logic             fall_pls,
    output logic [CNT_W-1:0] hi_len,
    output logic [CNT_W-1:0] lo_len,
    output logic             meas_vld,
    output logic             locked,
    output logic             err
`ifdef DIV_CHK_ERR_CNT_EN
    ,
    output logic [ERR_CNT_W-1:0] err_cnt
`endif
);

    localparam int GOOD_W = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT + 1);

    typedef enum logic [1:0] {
        S_INIT   = 2'd0,
        S_IDLE   = 2'd1,
        S_MEAS   = 2'd2,
        S_LOCKED = 2'd3
    } state_t;

    state_t              state_q;
    logic                d_q;
    logic [CNT_W-1:0]    run_cnt_q;
    logic [GOOD_W-1:0]   good_cnt_q;
    logic                hi_seen_q;
    logic                lo_seen_q;

    logic                edge_det;
    logic                run_sat;
    logic                phase_ok;
    logic [GOOD_W-1:0]   good_cnt_d;

    assign edge_det   = (state_q != S_INIT) && (clk_d != d_q);
    assign run_sat    = &run_cnt_q;
    assign phase_ok   = (run_cnt_q == exp_half) && (exp_half != '0);
    assign good_cnt_d = good_cnt_q + GOOD_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_INIT;
            d_q        <= 1'b0;
            run_cnt_q  <= '0;
            good_cnt_q <= '0;
            hi_seen_q  <= 1'b0;
            lo_seen_q  <= 1'b0;
            rise_pls   <= 1'b0;
            fall_pls   <= 1'b0;
            hi_len     <= '0;
            lo_len     <= '0;
            meas_vld   <= 1'b0;
            locked     <= 1'b0;
            err        <= 1'b0;
        end else begin
            d_q      <= clk_d;
            rise_pls <= 1'b0;
            fall_pls <= 1'b0;
            meas_vld <= 1'b0;
            err      <= 1'b0;
            case (state_q)
                S_INIT: state_q <= S_IDLE;
                default: begin
                    if (edge_det) begin
                        run_cnt_q <= CNT_W'(1);
                        rise_pls  <= clk_d;
                        fall_pls  <= ~clk_d;
                        if (state_q == S_IDLE) begin
                            // first phase after IDLE is partial, its length is dropped
                            state_q <= S_MEAS;
                        end else begin
                            if (clk_d) begin
                                lo_len    <= run_cnt_q;
                                lo_seen_q <= 1'b1;
                                meas_vld  <= hi_seen_q;
                            end else begin
                                hi_len    <= run_cnt_q;
                                hi_seen_q <= 1'b1;
                            end
                            if (phase_ok) begin
                                if (state_q == S_MEAS) begin
                                    good_cnt_q <= good_cnt_d;
                                    if (good_cnt_d == GOOD_W'(LOCK_CNT)) begin
                                        locked  <= 1'b1;
                                        state_q <= S_LOCKED;
                                    end
                                end
                            end else begin
                                err        <= 1'b1;
                                good_cnt_q <= '0;
                                locked     <= 1'b0;
                                state_q    <= S_MEAS;
                            end
                        end
                    end else if (!run_sat) begin
                        run_cnt_q <= run_cnt_q + CNT_W'(1);
                    end else if (state_q != S_IDLE) begin
                        // stuck clock: report once, then wait in IDLE for edges
                        err        <= 1'b1;
                        locked     <= 1'b0;
                        good_cnt_q <= '0;
                        hi_seen_q  <= 1'b0;
                        lo_seen_q  <= 1'b0;
                        state_q    <= S_IDLE;
                    end
                end
            endcase
        end
    end

`ifdef DIV_CHK_ERR_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (err && !(&err_cnt)) begin
            err_cnt <= err_cnt + ERR_CNT_W'(1);
        end
    end
`endif

endmodule
